// File: rtl/detector_jogada.sv
// Play detector: synchronises and debounces four buttons, emits one pulse per single-button press.
// Optional idle timeout pulse when built with DETECTOR_JOGADA_TIMEOUT_EN defined.
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter int TIMEOUT_CYCLES  = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilitar,
   input  logic [3:0] botoes,
   output logic       jogada_feita,
   output logic [3:0] jogada_valor,
   output logic       multiplo,
   output logic [2:0] db_estado
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   ,
   output logic       timeout
`endif
);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      FILTRA   = 3'd1,
      PULSO    = 3'd2,
      MULTIPLO = 3'd3,
      SOLTA    = 3'd4
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_chk_cnt
      $error("CNT_W too narrow for DEBOUNCE_CYCLES");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_to
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   estado_t          state_q, state_d;
   logic [3:0]       s1_q, bs_q;
   logic [1:0]       sync_valid_q, sync_valid_d;
   logic [3:0]       sample_q, sample_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bs_was_zero_q, bs_was_zero_d;
   logic             feita_q, feita_d;
   logic             mult_q, mult_d;
   logic [3:0]       valor_q, valor_d;

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   localparam int             TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_PRE = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] tcnt_q, tcnt_d;
   logic            to_q, to_d;
`endif

   // Next-state and output decode for the play FSM.
   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      cnt_d    = cnt_q;
      valor_d  = valor_q;
      feita_d  = 1'b0;
      mult_d   = 1'b0;
      case (state_q)
         OCIOSO: begin
            if (habilitar && (bs_q != 4'd0) && bs_was_zero_q) begin
               sample_d = bs_q;
               cnt_d    = CNT_W'(1);
               state_d  = FILTRA;
            end else begin
               state_d  = OCIOSO;
            end
         end
         FILTRA: begin
            if (!habilitar) begin
               state_d = OCIOSO;
            end else if (bs_q != sample_q) begin
               state_d = OCIOSO;
            end else if (cnt_q == CNT_LAST) begin
               if (is_one_hot(sample_q)) begin
                  state_d = PULSO;
                  feita_d = 1'b1;
                  valor_d = sample_q;
               end else begin
                  state_d = MULTIPLO;
                  mult_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PULSO, MULTIPLO: begin
            cnt_d   = '0;
            state_d = SOLTA;
         end
         SOLTA: begin
            if (bs_q != 4'd0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   // Release-seen flag; synchroniser zeros right after reset do not count as a real release.
   always_comb begin
      sync_valid_d = {sync_valid_q[0], 1'b1};
      if ((state_q == OCIOSO) && (state_d != OCIOSO)) begin
         bs_was_zero_d = 1'b0;
      end else if ((bs_q == 4'd0) && (sync_valid_q == 2'b11)) begin
         bs_was_zero_d = 1'b1;
      end else begin
         bs_was_zero_d = bs_was_zero_q;
      end
   end

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   // Idle timer: counts up to TIMEOUT_CYCLES, fires once, then spends one cycle cleared.
   always_comb begin
      to_d = 1'b0;
      if (!((state_q == OCIOSO) && habilitar && (bs_q == 4'd0))) begin
         tcnt_d = '0;
      end else if (tcnt_q == TO_MAX) begin
         tcnt_d = '0;
      end else begin
         tcnt_d = tcnt_q + TO_W'(1);
         to_d   = (tcnt_q == TO_PRE);
      end
   end
`endif

   // All state and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= OCIOSO;
         s1_q          <= 4'd0;
         bs_q          <= 4'd0;
         sync_valid_q  <= 2'b00;
         sample_q      <= 4'd0;
         cnt_q         <= '0;
         bs_was_zero_q <= 1'b0;
         feita_q       <= 1'b0;
         mult_q        <= 1'b0;
         valor_q       <= 4'd0;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
         tcnt_q        <= '0;
         to_q          <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         s1_q          <= botoes;
         bs_q          <= s1_q;
         sync_valid_q  <= sync_valid_d;
         sample_q      <= sample_d;
         cnt_q         <= cnt_d;
         bs_was_zero_q <= bs_was_zero_d;
         feita_q       <= feita_d;
         mult_q        <= mult_d;
         valor_q       <= valor_d;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
         tcnt_q        <= tcnt_d;
         to_q          <= to_d;
`endif
      end
   end

   assign jogada_feita = feita_q;
   assign jogada_valor = valor_q;
   assign multiplo     = mult_q;
   assign db_estado    = state_q;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   assign timeout      = to_q;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: directed steps plus random presses against a reference model.
module tb_detector_jogada;

   localparam int DB = 4;
   localparam int TO = 32;
   localparam int ST_IDLE = 0, ST_FILT = 1, ST_PULSE = 2, ST_CHORD = 3, ST_REL = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       habilitar = 1'b0;
   logic [3:0] botoes = 4'd0;
   logic       jogada_feita;
   logic [3:0] jogada_valor;
   logic       multiplo;
   logic [2:0] db_estado;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   logic       timeout;
`endif

   detector_jogada #(.DEBOUNCE_CYCLES(DB), .CNT_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .habilitar    (habilitar),
      .botoes       (botoes),
      .jogada_feita (jogada_feita),
      .jogada_valor (jogada_valor),
      .multiplo     (multiplo),
      .db_estado    (db_estado)
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
      ,
      .timeout      (timeout)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_feita = 0, n_mult = 0, last_feita = 0;

   // Reference model: pin history, phase, run length of stable cycles, release-seen flag.
   logic [3:0] pipe[$];
   int         m_phase, m_run, since_rst;
   logic [3:0] m_sample, m_valor;
   bit         m_armed, m_feita, m_mult;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   int         m_idle, n_to;
   bit         m_to;
   int         to_cyc[$];
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pipe = {4'd0, 4'd0};
      m_phase = ST_IDLE; m_run = 0; since_rst = 0;
      m_sample = 4'd0; m_valor = 4'd0;
      m_armed = 1'b0; m_feita = 1'b0; m_mult = 1'b0;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
      m_idle = 0; m_to = 1'b0;
`endif
   endtask

   task automatic model_step();
      logic [3:0] bs;
      int         prev;
      bit         real_input;
      bs = pipe[0];
      pipe.push_back(botoes);
      void'(pipe.pop_front());
      real_input = (since_rst >= 2);
      since_rst++;
      prev = m_phase;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
      m_to = 1'b0;
      if (!(prev == ST_IDLE && habilitar && bs == 4'd0)) m_idle = 0;
      else if (m_idle == TO) m_idle = 0;
      else begin
         m_idle++;
         m_to = (m_idle == TO);
      end
`endif
      if (prev == ST_IDLE) begin
         if (habilitar && bs != 4'd0 && m_armed) begin
            m_sample = bs; m_run = 1; m_phase = ST_FILT;
         end
      end else if (prev == ST_FILT) begin
         if (!habilitar || bs != m_sample) m_phase = ST_IDLE;
         else if (m_run == DB - 1) m_phase = ($countones(m_sample) == 1) ? ST_PULSE : ST_CHORD;
         else m_run++;
      end else if (prev == ST_PULSE || prev == ST_CHORD) begin
         m_run = 0; m_phase = ST_REL;
      end else begin
         if (bs != 4'd0) m_run = 0;
         else if (m_run == DB - 1) m_phase = ST_IDLE;
         else m_run++;
      end
      if (prev == ST_IDLE && m_phase != ST_IDLE) m_armed = 1'b0;
      else if (bs == 4'd0 && real_input) m_armed = 1'b1;
      m_feita = (m_phase == ST_PULSE);
      m_mult  = (m_phase == ST_CHORD);
      if (m_phase == ST_PULSE && prev != ST_PULSE) m_valor = m_sample;
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
      cyc++;
      #1;
      check("feita", 32'(jogada_feita), 32'(m_feita));
      check("multiplo", 32'(multiplo), 32'(m_mult));
      check("valor", 32'(jogada_valor), 32'(m_valor));
      check("estado", 32'(db_estado), 32'(m_phase));
      check("exclusive", 32'(jogada_feita & multiplo), 32'd0);
      if (jogada_feita === 1'b1) begin n_feita++; last_feita = cyc; end
      if (multiplo === 1'b1) n_mult++;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
      check("timeout", 32'(timeout), 32'(m_to));
      if (timeout === 1'b1) begin n_to++; to_cyc.push_back(cyc); end
`endif
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int         p, f0, m0;
      logic [3:0] one;
      model_reset();
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
      n_to = 0;
`endif
      #2;
      check("rst_feita", 32'(jogada_feita), 32'd0);
      check("rst_valor", 32'(jogada_valor), 32'd0);
      check("rst_mult", 32'(multiplo), 32'd0);
      check("rst_estado", 32'(db_estado), 32'd0);
      hold(2);
      reset = 1'b0;
      habilitar = 1'b1;
      hold(5);

      // Clean press: the press cycle counts as the first of DB+3, so the pulse lands 6 edges later.
      f0 = n_feita; m0 = n_mult; p = cyc;
      botoes = 4'b0100; hold(20); botoes = 4'd0; hold(10);
      check("clean_count", 32'(n_feita - f0), 32'd1);
      check("clean_latency", 32'(last_feita - p), 32'd6);
      check("clean_valor", 32'(jogada_valor), 32'b0100);
      check("clean_mult", 32'(n_mult - m0), 32'd0);

      // Bounce, then a stable hold.
      f0 = n_feita;
      for (int i = 0; i < 6; i++) begin
         botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
         hold(2);
      end
      check("bounce_quiet", 32'(n_feita - f0), 32'd0);
      p = cyc; botoes = 4'b0100; hold(15); botoes = 4'd0; hold(10);
      check("bounce_count", 32'(n_feita - f0), 32'd1);
      check("bounce_latency", 32'(last_feita - p), 32'd6);

      // Chord is rejected and leaves the previous play in place.
      f0 = n_feita; m0 = n_mult;
      botoes = 4'b0011; hold(10); botoes = 4'd0; hold(10);
      check("chord_mult", 32'(n_mult - m0), 32'd1);
      check("chord_feita", 32'(n_feita - f0), 32'd0);
      check("chord_valor", 32'(jogada_valor), 32'b0100);

      // Release gating.
      f0 = n_feita; m0 = n_mult;
      botoes = 4'b0001; hold(8);
      check("gate_first", 32'(jogada_valor), 32'b0001);
      botoes = 4'b0011; hold(8);
      botoes = 4'd0;    hold(2);
      botoes = 4'b0010; hold(6);
      check("gate_short_release", 32'(n_feita - f0), 32'd1);
      botoes = 4'd0;    hold(8);
      botoes = 4'b0010; hold(10);
      botoes = 4'd0;    hold(10);
      check("gate_count", 32'(n_feita - f0), 32'd2);
      check("gate_valor", 32'(jogada_valor), 32'b0010);
      check("gate_mult", 32'(n_mult - m0), 32'd0);

      // Abort by dropping habilitar while filtering.
      f0 = n_feita;
      botoes = 4'b0100; hold(3);
      check("abort_in_filtra", 32'(db_estado), 32'd1);
      habilitar = 1'b0; hold(10);
      botoes = 4'd0; hold(6);
      habilitar = 1'b1; hold(4);
      check("abort_no_pulse", 32'(n_feita - f0), 32'd0);

      // Reset while filtering; the held press must never be accepted.
      botoes = 4'b0010; hold(3);
      check("reset_in_filtra", 32'(db_estado), 32'd1);
      reset = 1'b1;
      #1;
      model_reset();
      check("mid_rst_feita", 32'(jogada_feita), 32'd0);
      check("mid_rst_valor", 32'(jogada_valor), 32'd0);
      check("mid_rst_mult", 32'(multiplo), 32'd0);
      check("mid_rst_estado", 32'(db_estado), 32'd0);
      hold(2);
      reset = 1'b0;
      f0 = n_feita;
      hold(20);
      check("reset_no_pulse", 32'(n_feita - f0), 32'd0);
      botoes = 4'd0; hold(10);
      botoes = 4'b0001; hold(10); botoes = 4'd0; hold(10);
      check("reset_recover", 32'(n_feita - f0), 32'd1);
      check("reset_recover_valor", 32'(jogada_valor), 32'b0001);

      // Random presses, chords, releases and habilitar drops.
      for (int i = 0; i < 80; i++) begin
         int r;
         r = $urandom_range(0, 9);
         one = 4'b0001;
         if (r < 5) botoes = one << $urandom_range(0, 3);
         else if (r < 7) botoes = 4'd0;
         else botoes = 4'($urandom_range(0, 15));
         habilitar = ($urandom_range(0, 7) != 0);
         hold($urandom_range(1, 12));
      end
      botoes = 4'd0; habilitar = 1'b1; hold(10);

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
      begin
         int t0;
         habilitar = 1'b0; t0 = n_to;
         hold(40);
         check("to_disabled", 32'(n_to - t0), 32'd0);
         to_cyc.delete();
         habilitar = 1'b1; p = cyc;
         hold(70);
         check("to_count", 32'(to_cyc.size()), 32'd2);
         if (to_cyc.size() >= 2) begin
            check("to_first", 32'(to_cyc[0] - p), 32'd32);
            check("to_second", 32'(to_cyc[1] - p), 32'd65);
         end
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
